mc_controller: RTL and testbench

- Multicycle main-control FSM for the MIPS core.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the datapath mux selects and write enables, and supplies aluop to the existing ALU decoder.
- Talks to a variable-latency unified memory through a req/ready handshake, with a wait-timeout watchdog.

---
 rtl/mips_ctrl_pkg.sv | 34 +++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/mc_controller.sv | 165 ++++++++++++++++
 tb/tb_mc_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main-control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, ALUWB, ITYPEEX, IMMWB, BEQEX, BGTZEX, JEX
  } statetype;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b011101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; expired when TIMEOUT cycles have elapsed.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic waiting,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (waiting && cnt != LIMIT)
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mc_controller.sv
// Multicycle main-control FSM: sequences fetch/decode/execute/memory/writeback
// and handshakes with a variable-latency memory under a wait watchdog.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branchgt,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic       memerr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  statetype state;
  logic     inmem, waiting, expired, timeout;

  assign inmem   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign waiting = inmem && !memready;
  assign timeout = waiting && expired;

  // Clearing whenever the FSM is not about to stay in the same memory state
  // gives a zero count on entry to every memory state, including FETCH->FETCH after a timeout.
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!waiting || timeout),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (memready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW:                    state <= MEMADR;
            OP_RTYPE:                        state <= RTYPEEX;
            OP_BEQ:                          state <= BEQEX;
            OP_BGTZ:                         state <= BGTZEX;
            OP_ADDI, OP_XORI, OP_LUI, OP_LI: state <= ITYPEEX;
            OP_J:                            state <= JEX;
            default:                         state <= FETCH;
          endcase
        end
        MEMADR:  state <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD: begin
          if (memready)     state <= MEMWB;
          else if (timeout) state <= FETCH;
        end
        MEMWR:   if (memready || timeout) state <= FETCH;
        RTYPEEX: state <= ALUWB;
        ITYPEEX: state <= IMMWB;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    memreq   = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchgt = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    memerr   = 1'b0;
    if (!reset) begin
      memerr = timeout;
      case (state)
        FETCH: begin
          memreq  = 1'b1;
          alusrcb = SRCB_FOUR;
          irwrite = memready;
          pcwrite = memready;
        end
        DECODE: begin
          alusrcb = SRCB_IMMSH;
          illegal = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BGTZ,
                                 OP_ADDI, OP_XORI, OP_LUI, OP_LI, OP_J});
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        MEMRD: begin
          memreq = 1'b1;
          iord   = 1'b1;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        MEMWR: begin
          memreq   = 1'b1;
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        ITYPEEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          aluop   = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_ITYPE;
        end
        IMMWB:   regwrite = 1'b1;
        BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PCSRC_ALUOUT;
          branch  = 1'b1;
        end
        BGTZEX: begin
          alusrca  = 1'b1;
          aluop    = ALUOP_ITYPE;
          pcsrc    = PCSRC_ALUOUT;
          branchgt = 1'b1;
        end
        JEX: begin
          pcsrc   = PCSRC_JUMP;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction recipes expanded into
// expected per-cycle output words, driven with random ops, memory waits and resets.
module tb_mc_controller;

  localparam int unsigned TO = 4;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BGTZ = 6'b011101, ADDI = 6'b001000,
                         XORI = 6'b001110, LUI = 6'b001111, LI = 6'b010001,
                         J = 6'b000010;

  typedef struct packed {
    logic       memreq, memwrite, iord, irwrite, pcwrite, branch, branchgt;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal, memerr;
  } outs_t;

  typedef struct {
    outs_t      exp;
    logic       rdy;
    logic [5:0] op;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       memready = 1'b1;
  logic [5:0] op = '0;
  logic       memreq, memwrite, iord, irwrite, pcwrite, branch, branchgt;
  logic       regdst, memtoreg, regwrite, alusrca, illegal, memerr;
  logic [1:0] alusrcb, pcsrc, aluop;
  outs_t      obs;

  step_t q[$];
  int    checks = 0;
  int    failures = 0;

  mc_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .memreq(memreq), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .branchgt(branchgt), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal),
    .memerr(memerr)
  );

  always #5 clk = ~clk;

  assign obs = {memreq, memwrite, iord, irwrite, pcwrite, branch, branchgt,
                regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop,
                illegal, memerr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input outs_t e, input logic r, input logic [5:0] o);
    q.push_back('{exp: e, rdy: r, op: o});
  endtask

  // A memory access: 'waits' not-ready cycles then a ready cycle, or a
  // watchdog abort if the waits run past TO.
  task automatic mem_access(input outs_t base, input outs_t done, input int waits,
                            input logic [5:0] o, output bit ok);
    outs_t e;
    if (waits > int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) push(base, 1'b0, o);
      e = base;
      e.memerr = 1'b1;
      push(e, 1'b0, o);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < waits; i++) push(base, 1'b0, o);
      push(done, 1'b1, o);
      ok = 1'b1;
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {LW, SW, RT, BEQ, BGTZ, ADDI, XORI, LUI, LI, J};
  endfunction

  task automatic build(input logic [5:0] o, input int wf, input int wm);
    outs_t f, fd, d, x, m;
    bit    ok;
    q.delete();
    f = '0;
    f.memreq = 1'b1;
    f.alusrcb = 2'b01;
    fd = f;
    fd.irwrite = 1'b1;
    fd.pcwrite = 1'b1;
    mem_access(f, fd, wf, 6'($urandom), ok);
    if (!ok) return;
    d = '0;
    d.alusrcb = 2'b11;
    d.illegal = !is_legal(o);
    push(d, 1'($urandom), o);
    x = '0;
    case (o)
      LW, SW: begin
        x.alusrca = 1'b1; x.alusrcb = 2'b10;
        push(x, 1'($urandom), o);
        m = '0; m.memreq = 1'b1; m.iord = 1'b1; m.memwrite = (o == SW);
        mem_access(m, m, wm, o, ok);
        if (ok && o == LW) begin
          x = '0; x.memtoreg = 1'b1; x.regwrite = 1'b1;
          push(x, 1'($urandom), o);
        end
      end
      RT: begin
        x.alusrca = 1'b1; x.aluop = 2'b10;
        push(x, 1'($urandom), o);
        x = '0; x.regdst = 1'b1; x.regwrite = 1'b1;
        push(x, 1'($urandom), o);
      end
      ADDI, XORI, LUI, LI: begin
        x.alusrca = 1'b1; x.alusrcb = 2'b10; x.aluop = (o == ADDI) ? 2'b00 : 2'b11;
        push(x, 1'($urandom), o);
        x = '0; x.regwrite = 1'b1;
        push(x, 1'($urandom), o);
      end
      BEQ: begin
        x.alusrca = 1'b1; x.aluop = 2'b01; x.pcsrc = 2'b01; x.branch = 1'b1;
        push(x, 1'($urandom), o);
      end
      BGTZ: begin
        x.alusrca = 1'b1; x.aluop = 2'b11; x.pcsrc = 2'b01; x.branchgt = 1'b1;
        push(x, 1'($urandom), o);
      end
      J: begin
        x.pcsrc = 2'b10; x.pcwrite = 1'b1;
        push(x, 1'($urandom), o);
      end
      default: ;
    endcase
  endtask

  // Plays the expected trace; if reset_at hits a step, reset is asserted there
  // instead and the rest of the instruction is abandoned.
  task automatic run(input string name, input int reset_at);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (k == reset_at) begin
        reset = 1'b1;
        memready = 1'($urandom);
        op = q[k].op;
        #1;
        chk($sformatf("%s rst@%0d", name, k), 32'(obs), 32'd0);
        break;
      end
      reset = 1'b0;
      op = q[k].op;
      memready = q[k].rdy;
      #1;
      chk($sformatf("%s c%0d", name, k), 32'(obs), 32'(q[k].exp));
      chk($sformatf("%s c%0d memwr_noreq", name, k), 32'(memwrite & ~memreq), 32'd0);
      chk($sformatf("%s c%0d pcw_multi", name, k),
          32'((32'(pcwrite) + 32'(branch) + 32'(branchgt)) <= 32'd1), 32'd1);
    end
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 4) return 0;
    if (r <= 6) return int'($urandom_range(1, 2));
    if (r == 7) return int'(TO);
    if (r == 8) return int'(TO) + 1;
    return int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    logic [5:0] legal_ops [10];
    logic [5:0] o;
    int         ra;
    legal_ops = '{LW, SW, RT, BEQ, BGTZ, ADDI, XORI, LUI, LI, J};

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1;
      memready = 1'b1;
      #1;
      chk($sformatf("reset%0d", i), 32'(obs), 32'd0);
    end

    build(LW, 0, 0);            run("lw", -1);
    build(SW, 0, 3);            run("sw_wait3", -1);
    build(XORI, 0, 0);          run("xori", -1);
    build(ADDI, 1, 0);          run("addi", -1);
    build(6'b111111, 0, 0);     run("illegal", -1);
    build(BGTZ, 0, 0);          run("bgtz", -1);
    build(BEQ, 2, 0);           run("beq", -1);
    build(J, 0, 0);             run("j", -1);
    build(RT, 0, 0);            run("rtype", -1);
    build(LUI, TO + 1, 0);      run("fetch_timeout", -1);
    build(LI, TO, 0);           run("fetch_edge", -1);
    build(LW, 0, TO + 1);       run("lw_timeout", -1);
    build(SW, 0, TO);           run("sw_edge", -1);
    build(SW, 0, TO + 1);       run("sw_timeout", -1);
    build(LW, 0, 3);            run("lw_rst_memrd", 4);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 85) o = legal_ops[$urandom_range(0, 9)];
      else o = 6'($urandom);
      build(o, rand_wait(), rand_wait());
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      run($sformatf("rnd%0d", n), ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
